// File: rtl/dmem_responder.sv
// Byte-addressed data memory with valid/ready request/response channels and
// programmable wait states. Define DMEM_ALIGN_CHECK_EN to reject misaligned half/word accesses.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state, next_state;
  logic [CW-1:0] wait_cnt;
  logic          we_q;
  logic [2:0]    funct3_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          accept, access;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic          is_byte, is_half, is_word;
  logic          in_range, legal_f3, misaligned, err_c, do_write;
  logic [31:0]   load_data, st_data;
  logic [3:0]    st_be;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    access     = 1'b0;
    case (state)
      S_IDLE: if (req_valid && req_ready) begin
        accept     = 1'b1;
        next_state = S_WAIT;
      end
      S_WAIT: if (wait_cnt == '0) begin
        access     = 1'b1;
        next_state = S_RESP;
      end
      S_RESP: if (rsp_valid && rsp_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Handshake flags are registered copies of the upcoming state, so req_ready
  // only rises one edge after reset release or after a response handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wait_cnt  <= '0;
      we_q      <= 1'b0;
      funct3_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      req_ready <= (next_state == S_IDLE);
      rsp_valid <= (next_state == S_RESP);
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        wait_cnt <= CW'(WAIT_CYCLES);
      end else if (state == S_WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
      if (access) begin
        rsp_err   <= err_c;
        rsp_rdata <= (err_c || we_q) ? 32'h0 : load_data;
      end
    end
  end

  always_comb begin
    word_idx = addr_q[AW+1:2];
    rd_word  = mem[word_idx];
    is_byte  = (funct3_q[1:0] == 2'b00);
    is_half  = (funct3_q[1:0] == 2'b01);
    is_word  = (funct3_q[1:0] == 2'b10);
    in_range = ({1'b0, addr_q} < BYTE_LIMIT);
    case (funct3_q)
      3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
      3'b100, 3'b101:         legal_f3 = !we_q;
      default:                legal_f3 = 1'b0;
    endcase
`ifdef DMEM_ALIGN_CHECK_EN
    misaligned = (is_half && addr_q[0]) || (is_word && (addr_q[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
    err_c    = !in_range || !legal_f3 || misaligned;
    do_write = access && we_q && !err_c;
  end

  // Lane selection: halfwords use addr[1] only, words ignore the low bits.
  always_comb begin
    byte_sel  = rd_word[{addr_q[1:0], 3'b000} +: 8];
    half_sel  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = rd_word;
    if (is_byte)
      load_data = funct3_q[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
    else if (is_half)
      load_data = funct3_q[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
    st_data = wdata_q;
    st_be   = 4'b1111;
    if (is_byte) begin
      st_data = {4{wdata_q[7:0]}};
      st_be   = 4'b0001 << addr_q[1:0];
    end else if (is_half) begin
      st_data = {2{wdata_q[15:0]}};
      st_be   = addr_q[1] ? 4'b1100 : 4'b0011;
    end
  end

  // Array has no reset; contents survive reset assertion.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (do_write && st_be[b]) mem[word_idx][8*b +: 8] <= st_data[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (default parameters).
// Expectations follow DMEM_ALIGN_CHECK_EN when the bench is built with it.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  dmem_responder dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Drives a request and returns once it has been accepted (or the bound expires).
  task automatic send_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic ok);
    ok = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 req_valid = 1'b0;
  endtask

  // Counts edges from acceptance until rsp_valid is seen (capped at 30).
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (lat < 30) begin
      @(posedge clk);
      #1 lat++;
      if (rsp_valid) break;
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output logic err, output int lat);
    logic ok;
    send_req(we, f3, addr, wdata, ok);
    if (ok) wait_rsp(lat);
    else lat = 99;
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    #3;
    total++; if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_req_ready got=%b exp=0", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL ready_before_edge got=%b exp=0", req_ready); end
    @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL ready_after_edge got=%b exp=1", req_ready); end
  endtask

  task automatic test_word();
    logic [31:0] d; logic e; int lat;
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, d, e, lat);
    total++; if (lat !== 3) begin bad++; $display("[TB] FAIL sw_latency got=%0d exp=3", lat); end
    total++; if (d !== 32'h0 || e !== 1'b0) begin bad++; $display("[TB] FAIL sw_rsp got=%h/%b exp=0/0", d, e); end
    issue(1'b0, 3'b010, 32'h10, 32'h0, d, e, lat);
    total++; if (lat !== 3) begin bad++; $display("[TB] FAIL lw_latency got=%0d exp=3", lat); end
    total++; if (d !== 32'hDEADBEEF || e !== 1'b0) begin bad++; $display("[TB] FAIL lw_10 got=%h/%b exp=deadbeef/0", d, e); end
  endtask

  task automatic test_subword_loads();
    logic [31:0] d; logic e; int lat;
    logic [2:0]  f3s [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001};
    logic [31:0] ads [6] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h10, 32'h10};
    logic [31:0] exp [6] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000DEAD,
                             32'hFFFFFFEF, 32'hFFFFBEEF};
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, f3s[i], ads[i], 32'h0, d, e, lat);
      total++;
      if (d !== exp[i] || e !== 1'b0)
        begin bad++; $display("[TB] FAIL subload_%0d got=%h/%b exp=%h/0", i, d, e, exp[i]); end
    end
  endtask

  task automatic test_partial_stores();
    logic [31:0] d; logic e; int lat;
    issue(1'b1, 3'b000, 32'h11, 32'h12345655, d, e, lat);
    issue(1'b0, 3'b010, 32'h10, 32'h0, d, e, lat);
    total++; if (d !== 32'hDEAD55EF) begin bad++; $display("[TB] FAIL sb_merge got=%h exp=dead55ef", d); end
    issue(1'b1, 3'b001, 32'h10, 32'h0000ABCD, d, e, lat);
    issue(1'b0, 3'b010, 32'h10, 32'h0, d, e, lat);
    total++; if (d !== 32'hDEADABCD) begin bad++; $display("[TB] FAIL sh_merge got=%h exp=deadabcd", d); end
  endtask

  task automatic test_backpressure();
    logic ok; int lat; logic [31:0] d; logic e;
    rsp_ready = 1'b0;
    send_req(1'b0, 3'b010, 32'h10, 32'h0, ok);
    wait_rsp(lat);
    total++; if (lat !== 3) begin bad++; $display("[TB] FAIL bp_latency got=%0d exp=3", lat); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADABCD || rsp_err !== 1'b0 || req_ready !== 1'b0)
        begin bad++; $display("[TB] FAIL bp_hold_%0d got v=%b d=%h e=%b r=%b exp v=1 d=deadabcd e=0 r=0",
                              i, rsp_valid, rsp_rdata, rsp_err, req_ready); end
    end
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      begin bad++; $display("[TB] FAIL bp_release got v=%b r=%b exp v=0 r=1", rsp_valid, req_ready); end
    issue(1'b0, 3'b010, 32'h10, 32'h0, d, e, lat);
    total++; if (d !== 32'hDEADABCD) begin bad++; $display("[TB] FAIL bp_no_accept got=%h exp=deadabcd", d); end
  endtask

  task automatic test_errors();
    logic [31:0] d; logic e; int lat;
    issue(1'b0, 3'b010, 32'h12, 32'h0, d, e, lat);
`ifdef DMEM_ALIGN_CHECK_EN
    total++; if (d !== 32'h0 || e !== 1'b1) begin bad++; $display("[TB] FAIL lw_misaligned got=%h/%b exp=0/1", d, e); end
`else
    total++; if (d !== 32'hDEADABCD || e !== 1'b0) begin bad++; $display("[TB] FAIL lw_misaligned got=%h/%b exp=deadabcd/0", d, e); end
`endif
    total++; if (lat !== 3) begin bad++; $display("[TB] FAIL err_latency got=%0d exp=3", lat); end
    issue(1'b1, 3'b010, 32'h0, 32'h01020304, d, e, lat);
    issue(1'b1, 3'b010, 32'h400, 32'h55555555, d, e, lat);
    total++; if (d !== 32'h0 || e !== 1'b1) begin bad++; $display("[TB] FAIL sw_oor got=%h/%b exp=0/1", d, e); end
    issue(1'b0, 3'b010, 32'h0, 32'h0, d, e, lat);
    total++; if (d !== 32'h01020304 || e !== 1'b0) begin bad++; $display("[TB] FAIL oor_no_write got=%h/%b exp=01020304/0", d, e); end
    issue(1'b1, 3'b010, 32'h3FC, 32'hA5A5A5A5, d, e, lat);
    issue(1'b0, 3'b010, 32'h3FC, 32'h0, d, e, lat);
    total++; if (d !== 32'hA5A5A5A5 || e !== 1'b0) begin bad++; $display("[TB] FAIL last_word got=%h/%b exp=a5a5a5a5/0", d, e); end
    issue(1'b0, 3'b011, 32'h10, 32'h0, d, e, lat);
    total++; if (d !== 32'h0 || e !== 1'b1) begin bad++; $display("[TB] FAIL f3_011 got=%h/%b exp=0/1", d, e); end
    issue(1'b1, 3'b100, 32'h10, 32'h0, d, e, lat);
    total++; if (e !== 1'b1) begin bad++; $display("[TB] FAIL store_f3_100 got=%b exp=1", e); end
    issue(1'b0, 3'b010, 32'h10, 32'h0, d, e, lat);
    total++; if (d !== 32'hDEADABCD) begin bad++; $display("[TB] FAIL bad_store_no_write got=%h exp=deadabcd", d); end
  endtask

  task automatic test_reset_midop();
    logic [31:0] d; logic e; int lat; logic ok;
    issue(1'b1, 3'b010, 32'h20, 32'h2468ACE0, d, e, lat);
    issue(1'b0, 3'b010, 32'h20, 32'h0, d, e, lat);
    total++; if (d !== 32'h2468ACE0) begin bad++; $display("[TB] FAIL pre_reset_lw got=%h exp=2468ace0", d); end
    send_req(1'b1, 3'b010, 32'h20, 32'h11111111, ok);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0)
      begin bad++; $display("[TB] FAIL midop_reset got r=%b v=%b d=%h e=%b exp all 0",
                            req_ready, rsp_valid, rsp_rdata, rsp_err); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    issue(1'b0, 3'b010, 32'h20, 32'h0, d, e, lat);
    total++; if (d !== 32'h2468ACE0 || e !== 1'b0) begin bad++; $display("[TB] FAIL store_dropped got=%h/%b exp=2468ace0/0", d, e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic e; int lat;
    issue(1'b0, 3'b101, 32'h3FE, 32'h0, d, e, lat);
    total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL idle_after_hs got=%b exp=1", req_ready); end
    total++; if (d !== 32'h0000A5A5) begin bad++; $display("[TB] FAIL b2b_lhu got=%h exp=0000a5a5", d); end
    issue(1'b0, 3'b000, 32'h3FF, 32'h0, d, e, lat);
    total++; if (d !== 32'hFFFFFFA5 || lat !== 3) begin bad++; $display("[TB] FAIL b2b_lb got=%h lat=%0d exp=ffffffa5 lat=3", d, lat); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword_loads();
    test_partial_stores();
    test_backpressure();
    test_errors();
    test_reset_midop();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving the pipelined core's MEM-stage load/store requests over a valid/ready request channel and a valid/ready response channel. It holds a little-endian, byte-addressed word array. Each access is stretched by a configurable number of wait states, so the core's memory interface can be exercised with non-zero memory latency. Responses carry sign- or zero-extended load data and an error flag.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; byte address range 0 .. 4*DEPTH_WORDS-1.
- WAIT_CYCLES, 2: wait states inserted between request acceptance and the memory access (0 allowed).
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 funct3 (lb/lh/lw/lbu/lhu; sb/sh/sw).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or halfword is used for sb/sh.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  extended load data; 0 for stores and for errors.
- rsp_err  out  1  access rejected.

## Operation
- FSM states:
  - IDLE: req_ready=1. If req_valid is high at the edge, latch we/funct3/addr/wdata, load the wait counter with WAIT_CYCLES, go to WAIT.
  - WAIT: counter decrements each cycle. In the cycle the counter is 0, perform the access at the edge and go to RESP.
  - RESP: rsp_valid=1. If rsp_ready is high at the edge, go to IDLE.
- req_ready is registered and high only in IDLE. Requests presented in WAIT/RESP are ignored (no queueing).
- Legal loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Legal stores: 000 sb, 001 sh, 010 sw. Any other funct3 is an error.
- Loads:
  - byte lane = addr[1:0]; half lane = addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend.
- Stores: write only the addressed byte lanes; other bytes are unchanged.
- Out of range (addr >= 4*DEPTH_WORDS): rsp_err=1, no write, rsp_rdata=0.
- Error responses otherwise follow the normal latency and handshake.
- Store response: rsp_rdata=0, rsp_err=0 when legal.
- The memory array is not cleared by reset.

## Timing
- Reset values: state IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. req_ready rises at the first clk edge after reset deasserts.
- Request accepted at edge E. The access happens at edge E+WAIT_CYCLES+1, and rsp_valid is high in the cycle that follows that edge (3 cycles after acceptance with the default).
- Store data is visible to any load accepted after the store's response handshake.
- rsp_rdata and rsp_err are registered at the access edge and held stable while rsp_valid=1 and rsp_ready=0.
- After the response handshake edge there is one IDLE cycle (req_ready=1) before the next acceptance. Minimum request spacing is WAIT_CYCLES+3 cycles.
- rsp_ready high before rsp_valid has no effect.
- Reset mid-operation: asynchronous return to reset values. A store that has not reached its access edge is not performed, and any pending response is discarded.

## Configuration
- DMEM_ALIGN_CHECK_EN defined:
  - lh/lhu/sh with addr[0]=1 → rsp_err=1, no write, rdata=0.
  - lw/sw with addr[1:0]≠0 → rsp_err=1, no write, rdata=0.
- DMEM_ALIGN_CHECK_EN undefined:
  - no misalignment errors are raised.
  - halfword accesses ignore addr[0]; word accesses ignore addr[1:0].
  - out-of-range and illegal-funct3 errors are unchanged.

## Test plan
- Reset → sw 0xDEADBEEF @0x10 → lw @0x10 → rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid rising exactly 3 cycles after each acceptance.
- After the sw above:
  - lb @0x13 → 0xFFFFFFDE; lbu @0x13 → 0x000000DE.
  - lh @0x12 → 0xFFFFDEAD; lhu @0x12 → 0x0000DEAD.
- sb 0x12345655 @0x11, then lw @0x10 → 0xDEAD55EF; sh 0xABCD @0x10, then lw @0x10 → 0xDEADABCD.
- Backpressure: hold rsp_ready=0 for 5 cycles during a load response → rsp_valid, rsp_rdata, rsp_err stable, req_ready=0, and a concurrent req_valid is not accepted.
- Errors:
  - lw @0x12 → with macro rsp_err=1, rdata=0; without macro, returns the word @0x10.
  - sw @0x400 (DEPTH 256) → rsp_err=1, memory unchanged.
  - funct3=011 → rsp_err=1.
- Assert reset during the WAIT of sw 0x11111111 @0x20 → all outputs at reset values; a later lw @0x20 returns the prior contents.
